hazard_ctrl: RTL and testbench

- Pipeline control end of the five-stage MIPS datapath interface: consumes decoded D-stage instruction, drives datapath inputs stall, clr, mfcmp1dSel, mfcmp2dSel, mfaluaeSel, mfalubeSel, mfdeSel.
- Keeps its own shadow pipeline (E/M/W) of register-usage records, advanced in lockstep with datapath pipeline registers; stall/forward decisions come from the Tuse/Tnew model.

---
 rtl/hazard_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard control for the five-stage MIPS pipeline: keeps a shadow E/M/W record
// of register usage and derives stall/bubble and forwarding selects from Tuse/Tnew.
module hazard_ctrl #(
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_D,
  output logic             stall,
  output logic             clr,
  output logic [SEL_W-1:0] mfcmp1dSel,
  output logic [SEL_W-1:0] mfcmp2dSel,
  output logic [SEL_W-1:0] mfaluaeSel,
  output logic [SEL_W-1:0] mfalubeSel,
  output logic [SEL_W-1:0] mfdeSel
);

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_ALU  = 2'd1;
  localparam logic [1:0] SRC_DM   = 2'd2;
  localparam logic [1:0] SRC_PC   = 2'd3;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic [1:0] tnew;
    logic [1:0] src;
  } e_rec_t;

  // Later stages only keep the fields that are still consulted downstream.
  typedef struct packed {
    logic [4:0] rt;
    logic [4:0] dest;
    logic [1:0] tnew;
    logic [1:0] src;
  } m_rec_t;

  typedef struct packed {
    logic [4:0] dest;
    logic [1:0] src;
  } w_rec_t;

  typedef struct packed {
    e_rec_t     rec;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d.rec.rs   = instr[25:21];
    d.rec.rt   = instr[20:16];
    d.rec.dest = 5'd0;
    d.rec.tnew = 2'd0;
    d.rec.src  = SRC_NONE;
    d.tuse_rs  = TUSE_NONE;
    d.tuse_rt  = TUSE_NONE;
    case (instr[31:26])
      OP_RTYPE: begin
        // A non-zero shamt field makes these encodings undefined.
        if (instr[10:6] == 5'd0) begin
          case (instr[5:0])
            FN_ADDU, FN_SUBU: begin
              d.tuse_rs  = 2'd1;
              d.tuse_rt  = 2'd1;
              d.rec.dest = instr[15:11];
              d.rec.tnew = 2'd1;
              d.rec.src  = SRC_ALU;
            end
            FN_JR:   d.tuse_rs = 2'd0;
            default: d.tuse_rs = TUSE_NONE;
          endcase
        end else begin
          d.tuse_rs = TUSE_NONE;
        end
      end
      OP_ORI: begin
        d.tuse_rs  = 2'd1;
        d.rec.dest = instr[20:16];
        d.rec.tnew = 2'd1;
        d.rec.src  = SRC_ALU;
      end
      OP_LUI: begin
        d.rec.dest = instr[20:16];
        d.rec.tnew = 2'd1;
        d.rec.src  = SRC_ALU;
      end
      OP_LW: begin
        d.tuse_rs  = 2'd1;
        d.rec.dest = instr[20:16];
        d.rec.tnew = 2'd2;
        d.rec.src  = SRC_DM;
      end
      OP_SW: begin
        d.tuse_rs = 2'd1;
        d.tuse_rt = 2'd2;
      end
      OP_BEQ: begin
        d.tuse_rs = 2'd0;
        d.tuse_rt = 2'd0;
      end
      OP_JAL: begin
        d.rec.dest = 5'd31;
        d.rec.tnew = 2'd1;
        d.rec.src  = SRC_PC;
      end
      OP_J:    d.tuse_rs = TUSE_NONE;
      default: d.tuse_rs = TUSE_NONE;
    endcase
    return d;
  endfunction

  function automatic logic hit(input logic [4:0] r, input logic [1:0] tuse,
                               input e_rec_t e, input m_rec_t m);
    return (tuse != TUSE_NONE) && (r != 5'd0) &&
           (((e.dest == r) && (e.tnew > tuse)) || ((m.dest == r) && (m.tnew > tuse)));
  endfunction

  function automatic logic [SEL_W-1:0] fwd_w(input logic [4:0] r, input w_rec_t w);
    logic [SEL_W-1:0] sel;
    sel = SEL_W'(0);
    if ((r != 5'd0) && (w.dest == r)) begin
      case (w.src)
        SRC_ALU: sel = SEL_W'(3);
        SRC_DM:  sel = SEL_W'(4);
        SRC_PC:  sel = SEL_W'(5);
        default: sel = SEL_W'(0);
      endcase
    end else begin
      sel = SEL_W'(0);
    end
    return sel;
  endfunction

  function automatic logic [SEL_W-1:0] fwd_mw(input logic [4:0] r, input m_rec_t m,
                                              input w_rec_t w);
    logic [SEL_W-1:0] sel;
    sel = SEL_W'(0);
    if ((r != 5'd0) && (m.dest == r) && (m.tnew == 2'd0)) begin
      case (m.src)
        SRC_ALU: sel = SEL_W'(1);
        SRC_PC:  sel = SEL_W'(2);
        default: sel = SEL_W'(0);
      endcase
    end else begin
      sel = fwd_w(r, w);
    end
    return sel;
  endfunction

  dec_t   dec_s;
  e_rec_t e_r;
  m_rec_t m_r;
  m_rec_t m_next_s;
  w_rec_t w_r;
  logic   stall_s;

  // Decode the D-stage instruction and evaluate the Tuse/Tnew stall rule.
  always_comb begin
    dec_s   = decode(instr_D);
    stall_s = hit(dec_s.rec.rs, dec_s.tuse_rs, e_r, m_r) ||
              hit(dec_s.rec.rt, dec_s.tuse_rt, e_r, m_r);
  end

  // Record entering M: Tnew counts down by one, saturating at zero.
  always_comb begin
    m_next_s.rt   = e_r.rt;
    m_next_s.dest = e_r.dest;
    m_next_s.src  = e_r.src;
    if (e_r.tnew != 2'd0) begin
      m_next_s.tnew = e_r.tnew - 2'd1;
    end else begin
      m_next_s.tnew = 2'd0;
    end
  end

  // Shadow pipeline; M and W keep advancing while D/E are held.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_r <= '0;
      m_r <= '0;
      w_r <= '0;
    end else begin
      e_r      <= stall_s ? '0 : dec_s.rec;
      m_r      <= m_next_s;
      w_r.dest <= m_r.dest;
      w_r.src  <= m_r.src;
    end
  end

  // Drive control outputs, forced quiet while reset is asserted.
  always_comb begin
    if (reset) begin
      stall      = 1'b0;
      clr        = 1'b0;
      mfcmp1dSel = SEL_W'(0);
      mfcmp2dSel = SEL_W'(0);
      mfaluaeSel = SEL_W'(0);
      mfalubeSel = SEL_W'(0);
      mfdeSel    = SEL_W'(0);
    end else begin
      stall      = stall_s;
      clr        = stall_s;
      mfcmp1dSel = fwd_mw(dec_s.rec.rs, m_r, w_r);
      mfcmp2dSel = fwd_mw(dec_s.rec.rt, m_r, w_r);
      mfaluaeSel = fwd_mw(e_r.rs, m_r, w_r);
      mfalubeSel = fwd_mw(e_r.rt, m_r, w_r);
      mfdeSel    = fwd_w(m_r.rt, w_r);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

  localparam int SEL_W = 4;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic             clk;
  logic             reset;
  logic [31:0]      instr_D;
  logic             stall;
  logic             clr;
  logic [SEL_W-1:0] mfcmp1dSel;
  logic [SEL_W-1:0] mfcmp2dSel;
  logic [SEL_W-1:0] mfaluaeSel;
  logic [SEL_W-1:0] mfalubeSel;
  logic [SEL_W-1:0] mfdeSel;

  int total;
  int bad;

  hazard_ctrl #(.SEL_W(SEL_W)) dut (
    .clk(clk), .reset(reset), .instr_D(instr_D),
    .stall(stall), .clr(clr),
    .mfcmp1dSel(mfcmp1dSel), .mfcmp2dSel(mfcmp2dSel),
    .mfaluaeSel(mfaluaeSel), .mfalubeSel(mfalubeSel), .mfdeSel(mfdeSel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    instr_D = NOP;
    repeat (3) tick();
  endtask

  function automatic logic [31:0] addu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, 6'h21};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  logic [31:0] lw_1_2, addu_3_1_4, jal_i, jr_31;

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    instr_D = NOP;
    lw_1_2     = itype(6'h23, 5'd2, 5'd1, 16'd0);
    addu_3_1_4 = addu(5'd3, 5'd1, 5'd4);
    jal_i      = {6'h03, 26'h0000100};
    jr_31      = {6'h00, 5'd31, 15'd0, 6'h08};
    tick();
    instr_D = itype(6'h04, 5'd5, 5'd5, 16'd1);
    #1;
    check_val("rst_stall", {31'd0, stall}, 32'd0);
    check_val("rst_cmp1", {28'd0, mfcmp1dSel}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check_val("post_rst_stall", {31'd0, stall}, 32'd0);

    // 1: load-use stall then DM forward from W
    flush();
    instr_D = lw_1_2;
    tick();
    instr_D = addu_3_1_4;
    #1;
    check_val("t1_stall", {31'd0, stall}, 32'd1);
    check_val("t1_clr", {31'd0, clr}, 32'd1);
    tick();
    check_val("t1_stall2", {31'd0, stall}, 32'd0);
    tick();
    instr_D = NOP;
    #1;
    check_val("t1_aluae", {28'd0, mfaluaeSel}, 32'd4);
    check_val("t1_alube", {28'd0, mfalubeSel}, 32'd0);

    // rt-side load-use hazard
    flush();
    instr_D = itype(6'h23, 5'd2, 5'd4, 16'd0);
    tick();
    instr_D = addu(5'd3, 5'd5, 5'd4);
    #1;
    check_val("rt_stall", {31'd0, stall}, 32'd1);

    // j whose target bits alias rs=rt=1 reads nothing
    flush();
    instr_D = lw_1_2;
    tick();
    instr_D = {6'h02, 26'h0210000};
    #1;
    check_val("j_nostall", {31'd0, stall}, 32'd0);

    // 2: ALU result into branch compare
    flush();
    instr_D = addu(5'd5, 5'd6, 5'd7);
    tick();
    instr_D = itype(6'h04, 5'd5, 5'd0, 16'd3);
    #1;
    check_val("t2_stall", {31'd0, stall}, 32'd1);
    tick();
    check_val("t2_stall2", {31'd0, stall}, 32'd0);
    check_val("t2_cmp1", {28'd0, mfcmp1dSel}, 32'd1);
    check_val("t2_cmp2", {28'd0, mfcmp2dSel}, 32'd0);

    // 3: lw then sw of the loaded register
    flush();
    instr_D = itype(6'h23, 5'd6, 5'd4, 16'd0);
    #1;
    check_val("t3_stall_a", {31'd0, stall}, 32'd0);
    tick();
    instr_D = itype(6'h2b, 5'd6, 5'd4, 16'd8);
    #1;
    check_val("t3_stall_b", {31'd0, stall}, 32'd0);
    tick();
    instr_D = NOP;
    #1;
    check_val("t3_stall_c", {31'd0, stall}, 32'd0);
    check_val("t3_alube", {28'd0, mfalubeSel}, 32'd0);
    tick();
    check_val("t3_de", {28'd0, mfdeSel}, 32'd4);

    // 4: jal followed by jr $31 at distances 1, 2 and 3
    flush();
    instr_D = jal_i;
    tick();
    instr_D = jr_31;
    #1;
    check_val("t4_stall", {31'd0, stall}, 32'd1);
    tick();
    check_val("t4_stall2", {31'd0, stall}, 32'd0);
    check_val("t4_cmp1_m", {28'd0, mfcmp1dSel}, 32'd2);
    flush();
    instr_D = jal_i;
    tick();
    instr_D = NOP;
    tick();
    instr_D = jr_31;
    #1;
    check_val("t4_nop1_stall", {31'd0, stall}, 32'd0);
    check_val("t4_nop1_cmp1", {28'd0, mfcmp1dSel}, 32'd2);
    flush();
    instr_D = jal_i;
    tick();
    instr_D = NOP;
    tick();
    tick();
    instr_D = jr_31;
    #1;
    check_val("t4_nop2_stall", {31'd0, stall}, 32'd0);
    check_val("t4_nop2_cmp1", {28'd0, mfcmp1dSel}, 32'd5);

    // 5: M beats W; $0 never forwarded or stalled on
    flush();
    instr_D = itype(6'h0d, 5'd0, 5'd1, 16'd5);
    tick();
    instr_D = addu(5'd1, 5'd3, 5'd4);
    tick();
    instr_D = addu(5'd2, 5'd1, 5'd1);
    #1;
    check_val("t5_stall", {31'd0, stall}, 32'd0);
    tick();
    instr_D = NOP;
    #1;
    check_val("t5_aluae", {28'd0, mfaluaeSel}, 32'd1);
    check_val("t5_alube", {28'd0, mfalubeSel}, 32'd1);
    flush();
    instr_D = itype(6'h0f, 5'd0, 5'd0, 16'h1234);
    tick();
    instr_D = itype(6'h04, 5'd0, 5'd0, 16'd2);
    #1;
    check_val("t5_z_stall", {31'd0, stall}, 32'd0);
    check_val("t5_z_cmp1", {28'd0, mfcmp1dSel}, 32'd0);
    check_val("t5_z_cmp2", {28'd0, mfcmp2dSel}, 32'd0);

    // 6: reset while a load-use stall is pending
    flush();
    instr_D = lw_1_2;
    tick();
    instr_D = addu_3_1_4;
    #1;
    check_val("t6_pre_stall", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    #1;
    check_val("t6_rst_stall", {31'd0, stall}, 32'd0);
    check_val("t6_rst_clr", {31'd0, clr}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check_val("t6_post_stall", {31'd0, stall}, 32'd0);
    tick();
    instr_D = NOP;
    #1;
    check_val("t6_aluae", {28'd0, mfaluaeSel}, 32'd0);
    tick();
    check_val("t6_de", {28'd0, mfdeSel}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
